aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse-cipher core. Decrypts one 128-bit block per request, one round per clock, using a round-key bus produced by the existing key-expansion logic. It sits on the receive side of the AES datapath and consumes the ciphertext that the encryption path produces. It has valid/ready handshakes on both input and output so it can be placed directly in a streaming pipeline.

---
 rtl/aes_inv_cipher_iter.sv | 197 +++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES inverse cipher, one round per clock.
//
// Ports:
//   clk, reset       single clock; synchronous active-high reset
//   in_valid/in_ready/in            ciphertext input handshake (byte 0 in [127:120])
//   round_keys       expanded key, round key i at [128*(Nr+1)-1-128*i -: 128]
//   decryption_out   registered plaintext result
//   out_valid/out_ready             result handshake
//   busy             high from acceptance until the output handshake completes
//
// Optional feature macro: AES_INV_ROUNDKEY_LATCH_EN
//   defined   -> round_keys captured at acceptance; rounds use the copy
//   undefined -> round_keys used directly; must be held stable while busy
//
// Also contains aes_inv_sbox, the byte-wide inverse S-box lookup.
`timescale 1ns/1ps

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] TBL [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
  assign y = TBL[a];
endmodule

module aes_inv_cipher_iter #(
  parameter int Nk = 6,
  parameter int Nr = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in,
  input  logic [128*(Nr+1)-1:0] round_keys,
  output logic [127:0]          decryption_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  if (Nr != Nk + 6) begin : g_param_check
    $error("aes_inv_cipher_iter: Nr must equal Nk+6");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;

  logic [128*(Nr+1)-1:0] keys_src;
  logic [127:0]          rk [Nr+1];
  logic [127:0]          shifted, subbed, round_out, final_out;

`ifdef AES_INV_ROUNDKEY_LATCH_EN
  logic [128*(Nr+1)-1:0] keys_q;
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) keys_q <= round_keys;
  end
  assign keys_src = keys_q;
`else
  assign keys_src = round_keys;
`endif

  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rk[i] = keys_src[128*(Nr-i) +: 128];
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  assign shifted = inv_shift_rows(data_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (.a(shifted[127-8*i -: 8]), .y(subbed[127-8*i -: 8]));
  end

  assign round_out = inv_mix_columns(subbed ^ rk[cnt_q]);
  assign final_out = subbed ^ rk[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Round key Nr is the least significant slice of the bus.
          data_d  = in ^ round_keys[127:0];
          cnt_d   = 4'(Nr - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = round_out;
        if (cnt_q == 4'd1) state_d = FINAL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FINAL: begin
        out_d       = final_out;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      data_q      <= 128'h0;
      out_q       <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready       = (state_q == IDLE) && !reset;
  assign busy           = (state_q != IDLE);
  assign out_valid      = out_valid_q;
  assign decryption_out = out_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter with Nr = 10, 12 and 14 instances.
// Round keys come from a key expansion written here with an arithmetic S-box.
`timescale 1ns/1ps

module tb_aes_inv_cipher_iter;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct packed { logic [127:0] pt; int acc; } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic         iv10, ir10, ov10, or10, busy10;
  logic         iv12, ir12, ov12, or12, busy12;
  logic         iv14, ir14, ov14, or14, busy14;
  logic [127:0] in10, in12, in14, out10, out12, out14;
  logic [128*11-1:0] rk10;
  logic [128*13-1:0] rk12;
  logic [128*15-1:0] rk14;
  logic [1919:0]     full10, full12, full14;

  exp_t q10[$], q12[$], q14[$];
  exp_t e10, e12, e14;
  logic prev10 = 0, prev12 = 0, prev14 = 0;
  int   rises10 = 0, rises12 = 0, rises14 = 0;
  int   rise_last12 = 0, rise_prev12 = 0;
  int   acc12 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut10 (
    .clk(clk), .reset(reset), .in_valid(iv10), .in_ready(ir10), .in(in10),
    .round_keys(rk10), .decryption_out(out10), .out_valid(ov10), .out_ready(or10), .busy(busy10));
  aes_inv_cipher_iter #(.Nk(6), .Nr(12)) u_dut12 (
    .clk(clk), .reset(reset), .in_valid(iv12), .in_ready(ir12), .in(in12),
    .round_keys(rk12), .decryption_out(out12), .out_valid(ov12), .out_ready(or12), .busy(busy12));
  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut14 (
    .clk(clk), .reset(reset), .in_valid(iv14), .in_ready(ir14), .in(in14),
    .round_keys(rk14), .decryption_out(out14), .out_valid(ov14), .out_ready(or14), .busy(busy14));

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (x != 8'h00 && gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

  // Key bytes 00,01,02,...; round key 0 lands in the most significant slice.
  function automatic logic [1919:0] expand(input int nk, input int nr);
    logic [31:0]   w [60];
    logic [1919:0] rk;
    logic [31:0]   t;
    logic [7:0]    rc;
    int            n;
    n  = 4 * (nr + 1);
    rk = '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < n; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < n; j++) rk[32*(n-1-j) +: 32] = w[j];
    return rk;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard: push on acceptance ----------------
  always @(posedge clk) begin
    if (!reset && iv10 && ir10) q10.push_back('{PT, cyc + 1});
    if (!reset && iv12 && ir12) begin q12.push_back('{PT, cyc + 1}); acc12++; end
    if (!reset && iv14 && ir14) q14.push_back('{PT, cyc + 1});
  end

  // ---------------- monitors: pop on out_valid rising ----------------
  always @(negedge clk) begin
    if (ov12 && !prev12) begin
      if (q12.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out12_unexpected: got %h expected no output", out12);
      end else begin
        e12 = q12.pop_front();
        check("data12", out12, e12.pt);
        check("latency12", 128'(cyc - e12.acc), 128'd12);
      end
      rise_prev12 = rise_last12;
      rise_last12 = cyc;
      rises12++;
    end
    prev12 = ov12;
  end

  always @(negedge clk) begin
    if (ov10 && !prev10) begin
      if (q10.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out10_unexpected: got %h expected no output", out10);
      end else begin
        e10 = q10.pop_front();
        check("data10", out10, e10.pt);
        check("latency10", 128'(cyc - e10.acc), 128'd10);
      end
      rises10++;
    end
    prev10 = ov10;
  end

  always @(negedge clk) begin
    if (ov14 && !prev14) begin
      if (q14.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out14_unexpected: got %h expected no output", out14);
      end else begin
        e14 = q14.pop_front();
        check("data14", out14, e14.pt);
        check("latency14", 128'(cyc - e14.acc), 128'd14);
      end
      rises14++;
    end
    prev14 = ov14;
  end

  // ---------------- stimulus ----------------
  task automatic send12();
    @(negedge clk);
    in12 = CT12;
    iv12 = 1'b1;
    @(negedge clk);
    iv12 = 1'b0;
  endtask

  task automatic wait_rises12(input int target, input string name);
    for (int i = 0; i < 80 && rises12 < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, 128'(rises12), 128'(target));
  endtask

  initial begin
    int t0, a0;
    reset = 1'b1;
    iv10 = 0; iv12 = 0; iv14 = 0;
    or10 = 1; or12 = 1; or14 = 1;
    in10 = CT10; in12 = 128'h0; in14 = CT14;
    full10 = expand(4, 10);
    full12 = expand(6, 12);
    full14 = expand(8, 14);
    rk10 = full10[128*11-1:0];
    rk12 = full12[128*13-1:0];
    rk14 = full14[128*15-1:0];

    // Reset state
    @(negedge clk);
    check("in_ready_during_reset", 128'(ir12), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", 128'(ir12), 128'd1);
    check("out_valid_after_reset", 128'(ov12), 128'd0);
    check("busy_after_reset", 128'(busy12), 128'd0);
    check("out_after_reset", out12, 128'h0);

    // Basic AES-192 decryption
    t0 = rises12;
    send12();
    wait_rises12(t0 + 1, "basic_done");

    // Backpressure
    repeat (2) @(negedge clk);
    or12 = 1'b0;
    t0 = rises12;
    send12();
    for (int i = 0; i < 40 && !ov12; i++) begin
      @(negedge clk);
      #1;
    end
    check("bp_valid_seen", 128'(ov12), 128'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_stable", out12, PT);
      check("bp_valid_held", 128'(ov12), 128'd1);
      check("bp_in_ready_low", 128'(ir12), 128'd0);
      check("bp_busy_high", 128'(busy12), 128'd1);
      @(negedge clk);
      #1;
    end
    or12 = 1'b1;
    @(negedge clk);
    #1;
    check("bp_valid_dropped", 128'(ov12), 128'd0);
    check("bp_in_ready_back", 128'(ir12), 128'd1);

    // Back-to-back with in_valid held high
    repeat (2) @(negedge clk);
    t0 = rises12;
    a0 = acc12;
    in12 = CT12;
    iv12 = 1'b1;
    wait_rises12(t0 + 2, "b2b_done");
    iv12 = 1'b0;
    check("b2b_spacing", 128'(rise_last12 - rise_prev12), 128'd14);
    check("b2b_accepts", 128'(acc12 - a0), 128'd2);

    // Reset at edge T+5
    repeat (3) @(negedge clk);
    in12 = CT12;
    iv12 = 1'b1;
    @(negedge clk);
    iv12 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    q12.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(ov12), 128'd0);
    check("rst_mid_in_ready", 128'(ir12), 128'd1);
    check("rst_mid_out", out12, 128'h0);
    check("rst_mid_busy", 128'(busy12), 128'd0);
    t0 = rises12;
    send12();
    wait_rises12(t0 + 1, "post_reset_done");

    // AES-128 and AES-256 instances
    @(negedge clk);
    iv10 = 1'b1;
    iv14 = 1'b1;
    @(negedge clk);
    iv10 = 1'b0;
    iv14 = 1'b0;
    for (int i = 0; i < 40 && (rises10 < 1 || rises14 < 1); i++) begin
      @(negedge clk);
      #1;
    end
    check("sweep10_done", 128'(rises10), 128'd1);
    check("sweep14_done", 128'(rises14), 128'd1);

`ifdef AES_INV_ROUNDKEY_LATCH_EN
    // Keys removed after acceptance: captured copy must be used
    repeat (2) @(negedge clk);
    t0 = rises12;
    in12 = CT12;
    iv12 = 1'b1;
    @(negedge clk);
    iv12 = 1'b0;
    rk12 = '0;
    wait_rises12(t0 + 1, "latch_done");
    rk12 = full12[128*13-1:0];
`endif

    repeat (4) @(negedge clk);
    check("q10_drained", 128'(q10.size()), 128'd0);
    check("q12_drained", 128'(q12.size()), 128'd0);
    check("q14_drained", 128'(q14.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
